// File: rtl/dsp_pkg.sv
// dsp_pkg: state encoding and timing constants shared by the DSP frame scheduler.
package dsp_pkg;
    typedef enum logic [1:0] {IDLE, START, RUN} state_t;
    localparam int START_LEN   = 3;
    localparam int DONE_GUARD  = 2;
    localparam int FRAME_W_DEF = 5;
    localparam int CNT_W_DEF   = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge ck or negedge rst)
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/dsp_scheduler.sv
// dsp_scheduler: starts one sequencer run per audio frame, buffering one frame
// and flagging dropped frames and sequencer timeouts.
module dsp_scheduler
    import dsp_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int TIMEOUT = 300,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_strobe,
    input  logic               seq_done,
    input  logic               clear_err,
    output logic               seq_rst,
    output logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               error,
    output logic               overrun,
    output logic [CNT_W-1:0]   overrun_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [1:0]    scnt;
    logic [TW-1:0] tcnt;
    logic          pending, go, done_ok, timeout, overrun_ev;

    always_comb begin
        done_ok    = state == RUN && tcnt >= TW'(DONE_GUARD) && seq_done;
        timeout    = state == RUN && !done_ok && tcnt == TW'(TIMEOUT - 1);
        go         = enable && (frame_strobe || pending) && (state == IDLE || done_ok);
        overrun_ev = enable && frame_strobe && pending && !go;
        busy       = state != IDLE;
    end

    // A strobe arriving with a pending frame that is consumed this cycle becomes the new pending frame.
    always_ff @(posedge ck or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            seq_rst <= 1'b0;
            frame   <= '0;
            pending <= 1'b0;
            error   <= 1'b0;
            overrun <= 1'b0;
            scnt    <= '0;
            tcnt    <= '0;
        end else begin
            pending <= enable && !timeout && (go ? frame_strobe && pending : pending || frame_strobe);
            error   <= !clear_err && (error || timeout);
            overrun <= !clear_err && (overrun || overrun_ev);
            if (go) begin
                state   <= START;
                seq_rst <= 1'b0;
                frame   <= frame + 1'b1;
                scnt    <= '0;
            end else if (timeout) begin
                state   <= IDLE;
                seq_rst <= 1'b0;
            end else if (done_ok) begin
                state <= IDLE;
            end else if (state == START) begin
                scnt <= scnt + 1'b1;
                if (scnt == 2'(START_LEN - 1)) begin
                    state   <= RUN;
                    seq_rst <= 1'b1;
                    tcnt    <= '0;
                end
            end else if (state == RUN) begin
                tcnt <= tcnt + 1'b1;
            end
        end

    sat_counter #(.W(CNT_W)) u_ovr_cnt (
        .ck   (ck),
        .rst  (rst),
        .inc  (overrun_ev),
        .clr  (clear_err),
        .count(overrun_count)
    );
endmodule
